// File: rtl/temporal_ngram_encoder_pkg.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder_pkg
//   Shared system-level constants for the hypervector encoder datapath.
//   HV_DIMENSION : hypervector width in bits used by every encoder stage.
//   NGRAM_SIZE   : default number of samples bound into one n-gram.
//   NGRAM_MAX    : largest window the temporal encoder supports.
//   cnt_width()  : width of the in-window sample counter (never below 1).
// -----------------------------------------------------------------------------
package temporal_ngram_encoder_pkg;

  localparam int HV_DIMENSION = 64;
  localparam int NGRAM_SIZE   = 3;
  localparam int NGRAM_MAX    = 8;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/temporal_ngram_encoder_hv_permute.sv
// -----------------------------------------------------------------------------
// hv_permute
//   Hypervector permutation rho(): circular left rotate by one bit.
//   Pure wiring, no logic; shared by every encoder that needs the permutation.
//   Ports:
//     hv     : input  hypervector
//     hv_rot : output rho(hv) = {hv[DIM-2:0], hv[DIM-1]}
// -----------------------------------------------------------------------------
module hv_permute
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int DIM = HV_DIMENSION
) (
  input  logic [DIM-1:0] hv,
  output logic [DIM-1:0] hv_rot
);

  assign hv_rot = {hv[DIM-2:0], hv[DIM-1]};

endmodule

// File: rtl/temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder
//   Groups a stream of spatial hypervectors into non-overlapping windows of
//   NGRAM samples and binds each window into one n-gram hypervector:
//     hvout = rho^(N-1)(s0) ^ rho^(N-2)(s1) ^ ... ^ s(N-1)
//   The binding is built incrementally (acc = rho(acc) ^ sample), so the
//   datapath is one rotate (wiring) plus one XOR per cycle.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous active-low reset
//     hvin_valid   : upstream sample valid
//     hvin_ready   : sample can be accepted this cycle
//     hvin         : spatial hypervector sample
//     hvout_valid  : n-gram hypervector available
//     hvout_ready  : downstream accepts the n-gram
//     hvout        : n-gram hypervector (straight from a register)
// -----------------------------------------------------------------------------
module temporal_ngram_encoder
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int NGRAM = NGRAM_SIZE,
  parameter int DIM   = HV_DIMENSION
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hvin_valid,
  output logic           hvin_ready,
  input  logic [DIM-1:0] hvin,
  output logic           hvout_valid,
  input  logic           hvout_ready,
  output logic [DIM-1:0] hvout
);

  localparam int               CNT_W = cnt_width(NGRAM);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NGRAM - 1);

  generate
    if (NGRAM < 1 || NGRAM > NGRAM_MAX) begin : g_bad_ngram
      $error("temporal_ngram_encoder: NGRAM must be in 1..8");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [DIM-1:0]   acc;
  logic [DIM-1:0]   acc_rot;
  logic [DIM-1:0]   bound;
  logic             last;
  logic             hvin_fire;
  logic             hvout_fire;

  hv_permute #(.DIM(DIM)) u_permute (
    .hv     (acc),
    .hv_rot (acc_rot)
  );

  // First sample of a window starts a fresh binding; acc may hold a stale
  // value from the previous window, which is intentionally ignored here.
  assign bound = (cnt == '0) ? hvin : (acc_rot ^ hvin);

  assign last = (cnt == LAST);

  // Only the window-closing sample needs the output slot, so it is the only
  // one that can be stalled; earlier samples keep accumulating meanwhile.
  assign hvin_ready = !(last && hvout_valid && !hvout_ready);

  assign hvin_fire  = hvin_valid && hvin_ready;
  assign hvout_fire = hvout_valid && hvout_ready;

  // ---- datapath: partial binding and result register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      hvout <= '0;
    end else if (hvin_fire) begin
      if (last) begin
        hvout <= bound;
      end else begin
        acc <= bound;
      end
    end
  end

  // ---- control: window position and output occupancy ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      hvout_valid <= 1'b0;
    end else begin
      if (hvin_fire) begin
        cnt <= last ? '0 : (cnt + 1'b1);
      end
      // A completing window wins over a drain in the same cycle, keeping
      // the slot occupied with the new result.
      if (hvin_fire && last) begin
        hvout_valid <= 1'b1;
      end else if (hvout_fire) begin
        hvout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_ngram_encoder
//   Drives three encoder instances (NGRAM = 1, 2, 3) with directed and random
//   samples. A reference model computes each n-gram from the window formula
//   and queues it; a monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_temporal_ngram_encoder;
  import temporal_ngram_encoder_pkg::*;

  localparam int DIM = HV_DIMENSION;

  logic           clk;
  logic           rst;
  logic [2:0]     vin;
  logic [2:0]     rdy;
  logic [2:0]     ovl;
  logic [2:0]     ord;
  logic [DIM-1:0] din  [3];
  logic [DIM-1:0] dout [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ng [3] = '{1, 2, 3};

  logic [DIM-1:0] win  [3][$];
  logic [DIM-1:0] expq [3][$];
  bit             prev_hold [3];
  logic [DIM-1:0] prev_data [3];

  temporal_ngram_encoder #(.NGRAM(1), .DIM(DIM)) u_dut1 (
    .clk(clk), .rst(rst), .hvin_valid(vin[0]), .hvin_ready(rdy[0]), .hvin(din[0]),
    .hvout_valid(ovl[0]), .hvout_ready(ord[0]), .hvout(dout[0]));
  temporal_ngram_encoder #(.NGRAM(2), .DIM(DIM)) u_dut2 (
    .clk(clk), .rst(rst), .hvin_valid(vin[1]), .hvin_ready(rdy[1]), .hvin(din[1]),
    .hvout_valid(ovl[1]), .hvout_ready(ord[1]), .hvout(dout[1]));
  temporal_ngram_encoder #(.NGRAM(3), .DIM(DIM)) u_dut3 (
    .clk(clk), .rst(rst), .hvin_valid(vin[2]), .hvin_ready(rdy[2]), .hvin(din[2]),
    .hvout_valid(ovl[2]), .hvout_ready(ord[2]), .hvout(dout[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [DIM-1:0] rot_left(input logic [DIM-1:0] x, input int k);
    return (x << k) | (x >> (DIM - k));
  endfunction

  function automatic logic [DIM-1:0] ngram3(input logic [DIM-1:0] a, input logic [DIM-1:0] b,
                                           input logic [DIM-1:0] c);
    return rot_left(a, 2) ^ rot_left(b, 1) ^ c;
  endfunction

  function automatic logic [DIM-1:0] rand_hv();
    logic [DIM-1:0] r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  task automatic chk(input string name, input logic [DIM-1:0] act, input logic [DIM-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: model on input transfers, compare on output transfers.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        prev_hold[i] = 1'b0;
      end else begin
        if (prev_hold[i]) begin
          chk($sformatf("hold_valid%0d", i), DIM'(ovl[i]), DIM'(1));
          chk($sformatf("hold_data%0d", i), dout[i], prev_data[i]);
        end
        prev_hold[i] = ovl[i] && !ord[i];
        prev_data[i] = dout[i];
        if (ovl[i] && ord[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("unexpected_out%0d", i), dout[i], 'x);
          end else begin
            chk($sformatf("sb_out%0d", i), dout[i], expq[i].pop_front());
          end
        end
        if (vin[i] && rdy[i]) begin
          win[i].push_back(din[i]);
          if (win[i].size() == ng[i]) begin
            logic [DIM-1:0] e;
            e = '0;
            for (int k = 0; k < ng[i]; k++) e ^= rot_left(win[i][k], ng[i] - 1 - k);
            expq[i].push_back(e);
            win[i].delete();
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample transferred.
  task automatic send(input int i, input logic [DIM-1:0] x);
    int  waitc;
    bit  done;
    waitc = 0;
    done  = 0;
    vin[i] = 1'b1;
    din[i] = x;
    while (!done) begin
      @(negedge clk);
      if (rdy[i]) done = 1;
      else begin
        waitc++;
        if (waitc > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout dut=%0d actual=stalled required=accepted", i);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input int i, input string name, input logic [DIM-1:0] req);
    @(negedge clk);
    chk({name, "_valid"}, DIM'(ovl[i]), DIM'(1));
    chk(name, dout[i], req);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  logic [DIM-1:0] ones, a, b, c, w1ref;

  initial begin
    rst = 1'b0;
    vin = '0;
    ord = 3'b111;
    for (int i = 0; i < 3; i++) din[i] = '0;
    ones = '1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), DIM'(rdy[i]), DIM'(1));
      chk($sformatf("rst_valid%0d", i), DIM'(ovl[i]), DIM'(0));
      chk($sformatf("rst_hvout%0d", i), dout[i], '0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic bind
    send(2, DIM'(1)); send(2, '0); send(2, '0); vin[2] = 1'b0;
    check_out(2, "basic_bind", DIM'(4));

    // Wrap-around, and variant
    send(2, DIM'(1) << (DIM - 1)); send(2, DIM'(1)); send(2, '0); vin[2] = 1'b0;
    check_out(2, "wrap_cancel", '0);
    send(2, DIM'(1) << (DIM - 1)); send(2, DIM'(1) << 5); send(2, '0); vin[2] = 1'b0;
    check_out(2, "wrap_bits_1_6", (DIM'(1) << 1) | (DIM'(1) << 6));

    // All-ones
    send(2, ones); send(2, ones); send(2, ones); vin[2] = 1'b0;
    check_out(2, "ones_n3", ones);
    send(1, ones); send(1, ones); vin[1] = 1'b0;
    check_out(1, "ones_n2", '0);

    // Back-pressure
    ord[2] = 1'b0;
    a = rand_hv(); b = rand_hv(); c = rand_hv();
    w1ref = ngram3(a, b, c);
    send(2, a); send(2, b); send(2, c); vin[2] = 1'b0;
    @(negedge clk);
    chk("bp_w1_valid", DIM'(ovl[2]), DIM'(1));
    chk("bp_w1_data", dout[2], w1ref);
    @(posedge clk); #1;
    a = rand_hv(); b = rand_hv(); c = rand_hv();
    send(2, a); send(2, b);
    vin[2] = 1'b1; din[2] = c;
    @(negedge clk);
    chk("bp_stall", DIM'(rdy[2]), DIM'(0));
    chk("bp_hold_w1", dout[2], w1ref);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_stall2", DIM'(rdy[2]), DIM'(0));
    @(posedge clk); #1 ord[2] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", DIM'(rdy[2]), DIM'(1));
    chk("bp_release_w1", dout[2], w1ref);
    @(posedge clk); #1 vin[2] = 1'b0;
    check_out(2, "bp_w2", ngram3(a, b, c));
    drain();

    // Reset mid-window
    send(2, rand_hv()); send(2, rand_hv()); vin[2] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", DIM'(ovl[2]), DIM'(0));
    chk("mid_rst_hvout", dout[2], '0);
    chk("mid_rst_ready", DIM'(rdy[2]), DIM'(1));
    for (int i = 0; i < 3; i++) begin
      win[i].delete();
      expq[i].delete();
      prev_hold[i] = 1'b0;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    a = rand_hv(); b = rand_hv(); c = rand_hv();
    send(2, a); send(2, b); send(2, c); vin[2] = 1'b0;
    check_out(2, "post_rst", ngram3(a, b, c));

    // NGRAM=1 sustained flow
    begin
      int c0;
      c0 = cyc;
      for (int k = 0; k < 20; k++) send(0, rand_hv());
      chk("n1_sustained_cycles", DIM'(cyc - c0), DIM'(20));
      vin[0] = 1'b0;
    end
    drain();

    // Random traffic with random back-pressure on all instances
    for (int i = 0; i < 3; i++) begin
      bit stop;
      stop = 0;
      fork
        begin
          for (int k = 0; k < 12 * ng[i]; k++) begin
            send(i, rand_hv());
            if ($urandom_range(0, 3) == 0) begin
              vin[i] = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
          end
          vin[i] = 1'b0;
          stop = 1;
        end
        begin
          while (!stop) begin
            @(posedge clk);
            #1 ord[i] = ($urandom_range(0, 3) != 0);
          end
        end
      join
      ord[i] = 1'b1;
      drain();
    end

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("leftover_exp%0d", i), DIM'(expq[i].size()), DIM'(0));
      chk($sformatf("leftover_win%0d", i), DIM'(win[i].size()), DIM'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
